sp_dram_word: RTL and testbench

Word-width front end for `sp_dram`. It accepts 32-bit word reads and writes from a kernel memory port and turns them into 128-bit line commands with byte masks on the DRAM controller's `addr`/`din`/`mask`/`we`/`re`/`ready`/`dout` interface. It keeps a single-line read buffer, so repeated reads within one line complete without a DRAM transaction. Writes always go through to DRAM and update the buffer on a hit.

---
 rtl/sp_dram_word.sv | 181 ++++++++++++++++++
 tb/tb_sp_dram_word.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_dram_word.sv
// sp_dram_word: 32-bit word front end for the sp_dram line controller.
//
// Kernel word reads and writes come in. They leave as 128-bit line
// commands with byte masks. A single-line read buffer lets repeated reads
// within one line complete locally. Writes always go through to DRAM, and
// they patch the buffer when they hit it.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   addr[26:0]      word address: [26:2] line, [1:0] word within the line
//   din[31:0]       write data
//   we, re          request strobes, sampled only while ready=1
//   dout[31:0]      read data, held until the next read completes
//   ready           idle and able to accept a request
//   mem_addr[24:0]  line address to sp_dram
//   mem_din[127:0]  line write data (the word replicated 4x)
//   mem_mask[15:0]  byte enables, 1 = write byte (0 outside WR_REQ)
//   mem_we, mem_re  one-cycle line strobes
//   mem_dout[127:0] line read data from sp_dram
//   mem_ready       sp_dram ready
//
// Handshake: a request is taken on a rising edge where ready=1 and we or
// re is high. we wins over re. Requests seen while ready=0 are dropped,
// not queued. On the DRAM side, a strobe is raised only in a cycle where
// mem_ready=1, so the command transfers in that same cycle.

module sp_dram_word #(
  parameter logic ENABLE_BUFFER = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [26:0]  addr,
  input  logic [31:0]  din,
  input  logic         we,
  input  logic         re,
  output logic [31:0]  dout,
  output logic         ready,
  output logic [24:0]  mem_addr,
  output logic [127:0] mem_din,
  output logic [15:0]  mem_mask,
  output logic         mem_we,
  output logic         mem_re,
  input  logic [127:0] mem_dout,
  input  logic         mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_GAP  = 3'd3,
    S_RD_WAIT = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [26:0]    req_addr_q, req_addr_d;
  logic [31:0]    req_din_q, req_din_d;
  logic [127:0]   line_q, line_d;
  logic [24:0]    tag_q, tag_d;
  logic           valid_q, valid_d;
  logic [31:0]    dout_q, dout_d;

  logic           rd_hit;
  logic           wr_hit;

  function automatic logic [31:0] word_sel(input logic [127:0] l, input logic [1:0] w);
    logic [31:0] r;
    case (w)
      2'd0:    r = l[31:0];
      2'd1:    r = l[63:32];
      2'd2:    r = l[95:64];
      default: r = l[127:96];
    endcase
    return r;
  endfunction

  // The incoming request is compared against the buffer tag. A write in
  // flight is compared using its latched address.
  assign rd_hit = ENABLE_BUFFER && valid_q && (tag_q == addr[26:2]);
  assign wr_hit = ENABLE_BUFFER && valid_q && (tag_q == req_addr_q[26:2]);

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_din_d  = req_din_q;
    line_d     = line_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    dout_d     = dout_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_mask   = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (we) begin
          req_addr_d = addr;
          req_din_d  = din;
          state_d    = S_WR_REQ;
        end else if (re) begin
          if (rd_hit) begin
            dout_d = word_sel(line_q, addr[1:0]);
          end else begin
            req_addr_d = addr;
            req_din_d  = din;
            state_d    = S_RD_REQ;
          end
        end
      end

      S_WR_REQ: begin
        mem_mask = 16'h000F << {req_addr_q[1:0], 2'b00};
        mem_we   = mem_ready;
        if (mem_ready) begin
          // Keep the buffered copy coherent with what DRAM now holds.
          if (wr_hit) begin
            for (int i = 0; i < 4; i++) begin
              if (req_addr_q[1:0] == i[1:0]) begin
                line_d[32*i +: 32] = req_din_q;
              end
            end
          end
          state_d = S_IDLE;
        end
      end

      S_RD_REQ: begin
        mem_re = mem_ready;
        if (mem_ready) begin
          state_d = S_RD_GAP;
        end
      end

      // sp_dram still shows ready in the cycle right after the strobe.
      // Skipping that cycle keeps a stale ready from being taken as data.
      S_RD_GAP: begin
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (mem_ready) begin
          line_d  = mem_dout;
          tag_d   = req_addr_q[26:2];
          valid_d = 1'b1;
          dout_d  = word_sel(mem_dout, req_addr_q[1:0]);
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_din_q  <= '0;
      line_q     <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_din_q  <= req_din_d;
      line_q     <= line_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign dout     = dout_q;
  assign mem_addr = req_addr_q[26:2];
  assign mem_din  = {4{req_din_q}};

endmodule

// File: tb/tb_sp_dram_word.sv
module tb_sp_dram_word;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (buffer enabled) ----------------
  logic [26:0]  addr = '0;
  logic [31:0]  din = '0;
  logic         we = 1'b0, re = 1'b0;
  logic [31:0]  dout;
  logic         ready;
  logic [24:0]  mem_addr;
  logic [127:0] mem_din;
  logic [15:0]  mem_mask;
  logic         mem_we, mem_re;
  logic [127:0] mem_dout = '0;
  logic         mem_ready;

  sp_dram_word #(.ENABLE_BUFFER(1'b1)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .we(we), .re(re),
    .dout(dout), .ready(ready), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_mask(mem_mask), .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  // ---------------- second DUT (buffer disabled, always-ready DRAM) ----------------
  logic [26:0]  addr2 = '0;
  logic [31:0]  din2 = '0;
  logic         we2 = 1'b0, re2 = 1'b0;
  logic [31:0]  dout2;
  logic         ready2;
  logic [24:0]  mem_addr2;
  logic [127:0] mem_din2;
  logic [15:0]  mem_mask2;
  logic         mem_we2, mem_re2;
  logic [127:0] mem_dout2;

  assign mem_dout2 = {4{32'hA5A5_0000 | {7'b0, mem_addr2}}};

  sp_dram_word #(.ENABLE_BUFFER(1'b0)) u_nobuf (
    .clk(clk), .rst(rst), .addr(addr2), .din(din2), .we(we2), .re(re2),
    .dout(dout2), .ready(ready2), .mem_addr(mem_addr2), .mem_din(mem_din2),
    .mem_mask(mem_mask2), .mem_we(mem_we2), .mem_re(mem_re2),
    .mem_dout(mem_dout2), .mem_ready(1'b1)
  );

  // ---------------- behavioural DRAM model ----------------
  logic [127:0] dram_mem [0:15];
  logic         mdl_ready = 1'b1;
  int           busy = 0;
  logic [3:0]   pend = '0;
  int           rd_lat = 5;
  logic         dram_stall = 1'b0;
  logic         pl_en = 1'b0;
  logic [3:0]   pl_idx = '0;
  logic [127:0] pl_data = '0;
  logic [127:0] mdl_tmp;

  assign mem_ready = mdl_ready & ~dram_stall;

  always @(posedge clk) begin
    if (pl_en) dram_mem[pl_idx] <= pl_data;
    if (mem_re) begin
      pend      <= mem_addr[3:0];
      busy      <= rd_lat;
      mdl_ready <= 1'b0;
    end else if (busy == 1) begin
      mdl_ready <= 1'b1;
      mem_dout  <= dram_mem[pend];
      busy      <= 0;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end
    if (mem_we) begin
      mdl_tmp = dram_mem[mem_addr[3:0]];
      for (int b = 0; b < 16; b++)
        if (mem_mask[b]) mdl_tmp[8*b +: 8] = mem_din[8*b +: 8];
      dram_mem[mem_addr[3:0]] <= mdl_tmp;
    end
  end

  // ---------------- strobe monitor ----------------
  int           re_cnt = 0, we_cnt = 0, both_cnt = 0, re2_cnt = 0, we2_cnt = 0;
  logic [24:0]  last_re_addr = '0, last_we_addr = '0;
  logic [15:0]  last_we_mask = '0;
  logic [127:0] last_we_din = '0;

  always @(negedge clk) begin
    if (mem_re) begin
      re_cnt       <= re_cnt + 1;
      last_re_addr <= mem_addr;
    end
    if (mem_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= mem_addr;
      last_we_mask <= mem_mask;
      last_we_din  <= mem_din;
    end
    if (mem_re && mem_we) both_cnt <= both_cnt + 1;
    if (mem_re2) re2_cnt <= re2_cnt + 1;
    if (mem_we2) we2_cnt <= we2_cnt + 1;
  end

  // ---------------- scoreboard / checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [127:0] data);
    pl_en = 1'b1; pl_idx = idx[3:0]; pl_data = data;
    tick();
    pl_en = 1'b0;
  endtask

  // Issue one request and wait for ready. cyc counts samples after the
  // accepting edge up to and including the first one with ready=1.
  task automatic run_op(input logic w, input logic r, input logic [26:0] a,
                        input logic [31:0] d, output int cyc, output int nre,
                        output int nwe, output logic saw_low);
    int re0, we0;
    re0 = re_cnt; we0 = we_cnt;
    we = w; re = r; addr = a; din = d;
    tick();
    we = 1'b0; re = 1'b0;
    cyc = 1;
    saw_low = !ready;
    while (!ready && cyc < 200) begin
      tick();
      cyc++;
    end
    nre = re_cnt - re0;
    nwe = we_cnt - we0;
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [26:0] a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    int          exp_re;
    int          exp_we;
  } vec_t;

  vec_t tbl [10];

  logic [31:0] ref_mem [0:63];
  logic        ref_valid;
  int          ref_tag;
  logic [31:0] ref_dout;

  localparam logic [127:0] L1 = 128'h33333333_22222222_11111111_00000000;

  initial begin
    int cyc, nre, nwe, r0, w0, n;
    logic low;

    tbl[0] = '{1'b0, 1'b1, 27'h6, 32'h0,        32'h22222222, 1, 0};
    tbl[1] = '{1'b0, 1'b1, 27'h7, 32'h0,        32'h33333333, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 27'h6, 32'hCAFEF00D, 32'h33333333, 0, 1};
    tbl[3] = '{1'b0, 1'b1, 27'h6, 32'h0,        32'hCAFEF00D, 0, 0};
    tbl[4] = '{1'b0, 1'b1, 27'h5, 32'h0,        32'hDEADBEEF, 0, 0};
    tbl[5] = '{1'b1, 1'b1, 27'h8, 32'h12345678, 32'hDEADBEEF, 0, 1};
    tbl[6] = '{1'b0, 1'b1, 27'h8, 32'h0,        32'h12345678, 1, 0};
    tbl[7] = '{1'b0, 1'b1, 27'h9, 32'h0,        32'h00000000, 0, 0};
    tbl[8] = '{1'b0, 1'b1, 27'h4, 32'h0,        32'h00000000, 1, 0};
    tbl[9] = '{1'b0, 1'b1, 27'h6, 32'h0,        32'hCAFEF00D, 0, 0};

    // ---- reset, checked while still asserted ----
    #1 rst = 1'b1;
    #2;
    check("rst_ready", ready, 1);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_dout", dout, 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      case (i)
        1:       preload(i, L1);
        4:       preload(i, {4{32'h44444444}});
        5:       preload(i, {4{32'h55555555}});
        6:       preload(i, {4{32'h66666666}});
        default: preload(i, '0);
      endcase
    end

    // ---- write, DRAM ready throughout ----
    w0 = we_cnt;
    we = 1'b1; addr = 27'h5; din = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 25'h1);
    check("wr_mem_mask", mem_mask, 16'h00F0);
    check("wr_mem_din_w1", mem_din[63:32], 32'hDEADBEEF);
    check("wr_ready_busy", ready, 0);
    tick();
    check("wr_ready_back", ready, 1);
    check("wr_one_we", we_cnt - w0, 1);
    check("wr_mask_idle", mem_mask, 16'h0000);
    check("wr_din_full", last_we_din, {4{32'hDEADBEEF}});

    // ---- write, DRAM stalled 3 cycles ----
    w0 = we_cnt;
    dram_stall = 1'b1;
    we = 1'b1; addr = 27'h5; din = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    tick();
    tick();
    check("stall_no_we", we_cnt - w0, 0);
    check("stall_ready", ready, 0);
    @(posedge clk);
    #1 dram_stall = 1'b0;
    tick();
    check("stall_we_late", we_cnt - w0, 1);
    check("stall_ready2", ready, 0);
    tick();
    check("stall_ready_back", ready, 1);

    // ---- table of word operations (read latency 5) ----
    rd_lat = 5;
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, cyc, nre, nwe, low);
      check($sformatf("tbl%0d_done", i), ready, 1);
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
      check($sformatf("tbl%0d_mem_re", i), nre, tbl[i].exp_re);
      check($sformatf("tbl%0d_mem_we", i), nwe, tbl[i].exp_we);
      check($sformatf("tbl%0d_ready_drop", i), low, (tbl[i].exp_re != 0) || (tbl[i].exp_we != 0));
      if (tbl[i].exp_re != 0)
        check($sformatf("tbl%0d_re_addr", i), last_re_addr, {2'b0, tbl[i].a[26:2]});
    end

    // ---- read miss, minimum latency: ready back in T+4 ----
    rd_lat = 1;
    run_op(1'b0, 1'b1, 27'd12, 32'h0, cyc, nre, nwe, low);
    check("miss_cycles", cyc, 4);
    check("miss_dout", dout, 32'h0);
    check("miss_mem_re", nre, 1);

    // ---- re pulsed while busy is ignored ----
    rd_lat = 5;
    r0 = re_cnt;
    re = 1'b1; addr = 27'd16;
    tick();
    re = 1'b0;
    tick();
    re = 1'b1; addr = 27'd20;
    tick();
    tick();
    re = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check("busy_done", ready, 1);
    check("busy_one_re", re_cnt - r0, 1);
    check("busy_dout", dout, 32'h44444444);
    run_op(1'b0, 1'b1, 27'd17, 32'h0, cyc, nre, nwe, low);
    check("busy_then_hit", nre, 0);
    check("busy_then_hit_dout", dout, 32'h44444444);

    // ---- reset while waiting for read data ----
    rd_lat = 10;
    re = 1'b1; addr = 27'd25;
    tick();
    re = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_mem_re", mem_re, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_dout", dout, 0);
    tick();
    rst = 1'b0;
    n = 0;
    while (!mem_ready && n < 50) begin
      tick();
      n++;
    end
    check("midrst_dram_idle", mem_ready, 1);
    tick();
    tick();
    check("midrst_not_captured", dout, 0);
    rd_lat = 2;
    run_op(1'b0, 1'b1, 27'd25, 32'h0, cyc, nre, nwe, low);
    check("midrst_reread_re", nre, 1);
    check("midrst_reread_dout", dout, 32'h66666666);

    // ---- buffer disabled: every read misses ----
    w0 = we2_cnt;
    we2 = 1'b1; addr2 = 27'h6; din2 = 32'hCAFEF00D;
    tick();
    we2 = 1'b0;
    tick();
    check("nobuf_we", we2_cnt - w0, 1);
    for (int k = 0; k < 2; k++) begin
      r0 = re2_cnt;
      re2 = 1'b1; addr2 = 27'h6;
      tick();
      re2 = 1'b0;
      n = 0;
      while (!ready2 && n < 50) begin
        tick();
        n++;
      end
      check($sformatf("nobuf_re%0d", k), re2_cnt - r0, 1);
      check($sformatf("nobuf_dout%0d", k), dout2, 32'hA5A50001);
    end

    // ---- randomized traffic against a word-level reference ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    ref_valid = 1'b0;
    ref_tag = -1;
    ref_dout = '0;
    for (int i = 0; i < 150; i++) begin
      int k, exp_re, exp_we;
      logic w, r;
      logic [26:0] a;
      logic [31:0] d;
      k = $urandom_range(0, 9);
      w = (k < 4) || (k == 9);
      r = (k >= 4);
      a = 27'(32 + $urandom_range(0, 15));
      d = $urandom;
      rd_lat = $urandom_range(1, 6);
      if (w) begin
        exp_we = 1; exp_re = 0;
        ref_mem[a[5:0]] = d;
      end else begin
        exp_we = 0;
        exp_re = (ref_valid && ref_tag == int'(a >> 2)) ? 0 : 1;
        ref_valid = 1'b1;
        ref_tag = int'(a >> 2);
        ref_dout = ref_mem[a[5:0]];
      end
      run_op(w, r, a, d, cyc, nre, nwe, low);
      check($sformatf("rnd%0d_dout", i), dout, ref_dout);
      check($sformatf("rnd%0d_mem_re", i), nre, exp_re);
      check($sformatf("rnd%0d_mem_we", i), nwe, exp_we);
    end

    check("re_we_never_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
